// File: rtl/led_pattern_pkg.sv
// Shared types and constants for the multi-channel LED pattern generator.
package led_pattern_pkg;

    typedef enum logic [1:0] {
        LED_OFF   = 2'd0,
        LED_ON    = 2'd1,
        LED_BLINK = 2'd2,
        LED_BURST = 2'd3
    } led_mode_t;

    typedef enum logic {
        BS_PULSE = 1'b0,
        BS_GAP   = 1'b1
    } burst_state_t;

    localparam int CH_IDX_W = 4;

endpackage

// File: rtl/led_pattern_blinker_channel.sv
// One LED channel: half-period counter, mode/settings registers, burst FSM and LED bit.
module led_channel
    import led_pattern_pkg::*;
#(
    parameter int CW           = 26,
    parameter int DEFAULT_HALF = 50_000_000,
    parameter int BW           = 4,
    parameter int GAP_HALVES   = 4
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            en,
    input  logic            cfg_load,
    input  led_mode_t       cfg_mode,
    input  logic [CW-1:0]   cfg_half,
    input  logic [BW-1:0]   cfg_burst,
    output logic            led
);

    // GAP_HALVES must be >= 1; the gap counter only needs to reach GAP_HALVES-1.
    localparam int GW = (GAP_HALVES < 2) ? 1 : $clog2(GAP_HALVES);

    led_mode_t    mode_q,  mode_d;
    burst_state_t st_q,    st_d;
    logic [CW-1:0] half_q,  half_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [BW-1:0] pcnt_q,  pcnt_d;
    logic [GW-1:0] gcnt_q,  gcnt_d;
    logic          led_q,   led_d;
    logic          term;

    assign term = (cnt_q == half_q - CW'(1));
    assign led  = led_q;

    always_comb begin
        mode_d  = mode_q;
        st_d    = st_q;
        half_d  = half_q;
        cnt_d   = cnt_q;
        burst_d = burst_q;
        pcnt_d  = pcnt_q;
        gcnt_d  = gcnt_q;
        led_d   = led_q;
        if (cfg_load) begin
            // A config load restarts the period and wins over a coincident terminal.
            mode_d  = cfg_mode;
            half_d  = (cfg_half == '0) ? CW'(1) : cfg_half;
            burst_d = (cfg_burst == '0) ? BW'(1) : cfg_burst;
            cnt_d   = '0;
            st_d    = BS_PULSE;
            pcnt_d  = '0;
            gcnt_d  = '0;
            led_d   = (cfg_mode == LED_ON);
        end else if (en) begin
            case (mode_q)
                LED_OFF: begin
                    led_d = 1'b0;
                    cnt_d = '0;
                end
                LED_ON: begin
                    led_d = 1'b1;
                    cnt_d = '0;
                end
                default: begin
                    cnt_d = term ? '0 : cnt_q + CW'(1);
                    if (term) begin
                        if (mode_q == LED_BLINK) begin
                            led_d = ~led_q;
                        end else if (st_q == BS_PULSE) begin
                            led_d = ~led_q;
                            // Pulses are counted on the falling toggle.
                            if (led_q) begin
                                if (pcnt_q + BW'(1) == burst_q) begin
                                    pcnt_d = '0;
                                    st_d   = BS_GAP;
                                end else begin
                                    pcnt_d = pcnt_q + BW'(1);
                                end
                            end
                        end else begin
                            led_d = 1'b0;
                            if (gcnt_q == GW'(GAP_HALVES - 1)) begin
                                gcnt_d = '0;
                                st_d   = BS_PULSE;
                                led_d  = 1'b1;
                            end else begin
                                gcnt_d = gcnt_q + GW'(1);
                            end
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            mode_q  <= LED_BLINK;
            st_q    <= BS_PULSE;
            half_q  <= CW'(DEFAULT_HALF);
            cnt_q   <= '0;
            burst_q <= BW'(1);
            pcnt_q  <= '0;
            gcnt_q  <= '0;
            led_q   <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            st_q    <= st_d;
            half_q  <= half_d;
            cnt_q   <= cnt_d;
            burst_q <= burst_d;
            pcnt_q  <= pcnt_d;
            gcnt_q  <= gcnt_d;
            led_q   <= led_d;
        end
    end

endmodule

// File: rtl/led_pattern_blinker.sv
// Multi-channel LED pattern generator: config handshake, channel decode and per-channel instances.
module led_pattern_blinker
    import led_pattern_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int CW           = 26,
    parameter int DEFAULT_HALF = 50_000_000,
    parameter int BW           = 4,
    parameter int GAP_HALVES   = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                en,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_IDX_W-1:0] cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [CW-1:0]       cfg_half,
    input  logic [BW-1:0]       cfg_burst,
    output logic                cfg_err,
    output logic [N_CH-1:0]     led
);

    logic            accept;
    logic            ch_bad;
    logic [N_CH-1:0] cfg_load;

    assign accept = cfg_valid && cfg_ready;
    assign ch_bad = {{(32-CH_IDX_W){1'b0}}, cfg_ch} >= 32'(N_CH);

    // cfg_ready only drops during reset; there is no other backpressure.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cfg_ready <= 1'b0;
            cfg_err   <= 1'b0;
        end else begin
            cfg_ready <= 1'b1;
            cfg_err   <= accept && ch_bad;
        end
    end

    generate
        for (genvar g = 0; g < N_CH; g++) begin : g_ch
            assign cfg_load[g] = accept && (cfg_ch == CH_IDX_W'(g));

            led_channel #(
                .CW           (CW),
                .DEFAULT_HALF (DEFAULT_HALF),
                .BW           (BW),
                .GAP_HALVES   (GAP_HALVES)
            ) u_ch (
                .clk       (clk),
                .reset_n   (reset_n),
                .en        (en),
                .cfg_load  (cfg_load[g]),
                .cfg_mode  (led_mode_t'(cfg_mode)),
                .cfg_half  (cfg_half),
                .cfg_burst (cfg_burst),
                .led       (led[g])
            );
        end
    endgenerate

endmodule
